// File: rtl/demux18_pkg.sv
// Shared constants and FSM state type for the 1:8 TDM demultiplexer.
package demux18_pkg;

   localparam int NUM_SLOTS = 8;
   localparam int SLOT_W    = 3;

   typedef enum logic [0:0] {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } demux18_state_e;

endpackage

// File: rtl/demux18_slot_ctr.sv
// Slot counter for the TDM demux: advances per consumed sample, reloads to 1
// when a sync sample is taken as slot 0, flags the last slot of a frame.
module demux18_slot_ctr
   import demux18_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              load1,
   output logic [SLOT_W-1:0] slot,
   output logic              wrap
);

   logic [SLOT_W-1:0] slot_d;
   logic [SLOT_W-1:0] slot_q;

   // next slot value
   always_comb begin
      slot_d = slot_q;
      if (load1) begin
         slot_d = SLOT_W'(1);
      end else if (inc) begin
         slot_d = slot_q + SLOT_W'(1);
      end else begin
         slot_d = slot_q;
      end
   end

   // slot register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= SLOT_W'(0);
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot = slot_q;
   assign wrap = (slot_q == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/demux18_tdm.sv
// Time-division 1:8 demultiplexer with frame sync and lock FSM.
// Define DEMUX18_SLOT_OUT_EN to expose the current slot on output s.
module demux18_tdm
   import demux18_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sync,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  y0,
   output logic [WIDTH-1:0]  y1,
   output logic [WIDTH-1:0]  y2,
   output logic [WIDTH-1:0]  y3,
   output logic [WIDTH-1:0]  y4,
   output logic [WIDTH-1:0]  y5,
   output logic [WIDTH-1:0]  y6,
   output logic [WIDTH-1:0]  y7,
   output logic              frame_valid,
   output logic              locked,
   output logic              sync_err
`ifdef DEMUX18_SLOT_OUT_EN
   ,
   output logic [SLOT_W-1:0] s
`endif
);

   demux18_state_e    state_d, state_q;
   logic [WIDTH-1:0]  hold_d [0:NUM_SLOTS-2];
   logic [WIDTH-1:0]  hold_q [0:NUM_SLOTS-2];
   logic [WIDTH-1:0]  y_d    [0:NUM_SLOTS-1];
   logic [WIDTH-1:0]  y_q    [0:NUM_SLOTS-1];
   logic              frame_valid_d, frame_valid_q;
   logic              sync_err_d, sync_err_q;
   logic              locked_d, locked_q;
   logic              slot_inc_s, slot_load_s, slot_wrap_s;
   logic [SLOT_W-1:0] slot_s;

   demux18_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc   (slot_inc_s),
      .load1 (slot_load_s),
      .slot  (slot_s),
      .wrap  (slot_wrap_s)
   );

   // next-state, hold capture and frame publish
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      y_d           = y_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      slot_inc_s    = 1'b0;
      slot_load_s   = 1'b0;
      if (en) begin
         case (state_q)
            ST_HUNT: begin
               if (sync) begin
                  hold_d[0]   = din;
                  slot_load_s = 1'b1;
                  state_d     = ST_LOCKED;
               end else begin
                  state_d     = ST_HUNT;
               end
            end
            ST_LOCKED: begin
               if (sync && (slot_s != SLOT_W'(0))) begin
                  // realign: the partial frame is dropped, this sample is slot 0
                  sync_err_d  = 1'b1;
                  hold_d[0]   = din;
                  slot_load_s = 1'b1;
               end else if (slot_wrap_s) begin
                  for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                     y_d[k] = hold_q[k];
                  end
                  y_d[NUM_SLOTS-1] = din;
                  frame_valid_d    = 1'b1;
                  slot_inc_s       = 1'b1;
               end else begin
                  for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                     if (slot_s == SLOT_W'(k)) begin
                        hold_d[k] = din;
                     end else begin
                        hold_d[k] = hold_q[k];
                     end
                  end
                  slot_inc_s = 1'b1;
               end
            end
            default: begin
               state_d = ST_HUNT;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      locked_d = (state_d == ST_LOCKED);
   end

   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_HUNT;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         locked_q      <= 1'b0;
         for (int k = 0; k < NUM_SLOTS - 1; k++) begin
            hold_q[k] <= '0;
         end
         for (int k = 0; k < NUM_SLOTS; k++) begin
            y_q[k] <= '0;
         end
      end else begin
         state_q       <= state_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
         locked_q      <= locked_d;
         hold_q        <= hold_d;
         y_q           <= y_d;
      end
   end

   assign y0          = y_q[0];
   assign y1          = y_q[1];
   assign y2          = y_q[2];
   assign y3          = y_q[3];
   assign y4          = y_q[4];
   assign y5          = y_q[5];
   assign y6          = y_q[6];
   assign y7          = y_q[7];
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;
   assign locked      = locked_q;
`ifdef DEMUX18_SLOT_OUT_EN
   assign s           = slot_s;
`endif

endmodule

// File: doc/demux18_tdm.md
# demux18_tdm

Time-division 1:8 demultiplexer: the receive end of the 8:1 mux path. A serial stream produced by cycling the mux select 0..7 is sampled one slot per enabled clock and rebuilt into eight registered channel outputs, presented as a whole frame with a one-cycle valid strobe. A frame-sync input aligns slot 0; a small lock state machine flags misaligned sync.

## Interface
- `WIDTH`, default 1: channel width in bits; `din` and `y0`..`y7` are all `WIDTH` wide.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  sample enable; one slot is consumed per clock with `en`=1.
- `sync`  in  1  frame marker; qualified by `en`; marks the current `din` as slot 0.
- `din`  in  WIDTH  serial TDM data, slot k = mux input ik.
- `y0`..`y7`  out  WIDTH each  demultiplexed channel k, registered, updated once per complete frame.
- `frame_valid`  out  1  one-cycle pulse: `y0`..`y7` just updated.
- `locked`  out  1  high in LOCKED state.
- `sync_err`  out  1  one-cycle pulse: sync seen at a slot other than 0 while LOCKED.

## Operation
- Internal state: `slot` (3-bit), `hold[0..6]` (WIDTH each), FSM {HUNT, LOCKED}.
- Reset (async, immediate): FSM=HUNT, `slot`=0, `hold`=0, `y0`..`y7`=0, `frame_valid`=0, `locked`=0, `sync_err`=0.
- `en`=0: no state change; `frame_valid`, `sync_err` drop to 0.
- HUNT, `en`=1, `sync`=0: sample discarded, stay HUNT.
- HUNT, `en`=1, `sync`=1: `hold[0]`<=`din`, `slot`<=1, go LOCKED.
- LOCKED, `en`=1, `sync`=0, `slot`=k<7: `hold[k]`<=`din`, `slot`<=k+1.
- LOCKED, `en`=1, `sync`=0, `slot`=7: `y0..y6`<=`hold[0..6]`, `y7`<=`din`, `frame_valid`<=1, `slot` wraps to 0. Missing sync at slot 0 is tolerated (flywheel).
- LOCKED, `en`=1, `sync`=1, `slot`=0: same as a normal slot-0 sample; no error.
- LOCKED, `en`=1, `sync`=1, `slot`≠0: `sync_err`<=1, partial frame discarded (no `frame_valid`), `hold[0]`<=`din`, `slot`<=1, stay LOCKED.
- `y0`..`y7` hold their last complete frame between updates; never show partial frames.

## Timing
- Latency: the edge that samples slot 7 loads all outputs; `frame_valid` is high for the following clock period only.
- With `en` tied high: one frame every 8 clocks, `frame_valid` 1 cycle in 8.
- `sync_err` registered on the offending edge, high for one cycle.
- `locked` asserts on the edge accepting the first sync; deasserts only on reset.
- Reset asserted mid-frame: outputs clear without a clock edge; first frame after release requires a new sync.

## Configuration
- `DEMUX18_SLOT_OUT_EN` defined: extra output `s` (3 bits) = current `slot` (the select value the next sample belongs to), reset 0; lets a bench drive the 8:1 mux select directly from the demux for loopback.
- Undefined: no `s` port; behaviour otherwise identical.

## Structure
- Shared package `demux18_pkg`: `NUM_SLOTS`=8, `SLOT_W`=3, FSM state enum (`ST_HUNT`, `ST_LOCKED`).
- One sub-module: `demux18_slot_ctr` (3-bit slot counter with enable, load-to-1 on sync, wrap flag at 7); FSM, hold registers and output registers stay in the top.

## Test plan
- Reset: `rst`=1 mid-stream -> all `y`=0, `frame_valid`=0, `locked`=0 immediately, with no clock edge.
- Aligned frame: `en`=1, `sync` on first sample, `din` = 0,1,0,1,0,1,0,1 -> on the 8th edge `y0..y7` = 0,1,0,1,0,1,0,1; `frame_valid` pulses one cycle; `locked`=1.
- Hunt: 5 samples with no `sync`, then sync plus pattern 1,1,0,0,1,1,0,0 -> only the synced frame appears; one `frame_valid` pulse.
- Enable gaps: the aligned frame with `en`=0 for 3 cycles after slot 3 -> same outputs; `frame_valid` 3 cycles later than the gapless case.
- Misaligned sync: sync again at slot 5 -> `sync_err` one-cycle pulse, no `frame_valid` for the broken frame, the next 8 samples form a correct frame.
- Flywheel: 3 consecutive frames with sync only on the first -> 3 `frame_valid` pulses, 8 cycles apart, and `sync_err`=0 throughout.
